rr_mux_arb: RTL and testbench

RR_MUX_ARB -- requirements
Module: rr_mux_arb

---
 rtl/rr_mux_arb.sv | 126 ++++++++++++
 tb/tb_rr_mux_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready multiplexer with a single-entry registered output stage.
// Channel choice is either a fixed index (mode_i=0) or round-robin arbitration (mode_i=1).
module rr_mux_arb #(
   parameter int WIDTH = 4,
   parameter int N     = 8,
   parameter int SW    = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mode_i,
   input  logic [SW-1:0]      sel_i,
   input  logic [N*WIDTH-1:0] in_data_i,
   input  logic [N-1:0]       in_valid_i,
   output logic [N-1:0]       in_ready_o,
   output logic [WIDTH-1:0]   out_data_o,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [SW-1:0]      out_sel_o
);

   localparam logic [SW:0]   N_C    = (SW+1)'(N);
   localparam logic [SW-1:0] PTR_RST = SW'(N - 1);

   logic [SW-1:0]    grant_s;
   logic             grant_valid_s;
   logic [SW:0]      cand_s;
   logic             ld_ok_s;
   logic             hs_s;
   logic [N-1:0]     in_ready_s;
   logic [WIDTH-1:0] sel_data_s;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SW-1:0]    out_sel_q, out_sel_d;
   logic             out_valid_q, out_valid_d;
   logic [SW-1:0]    ptr_q, ptr_d;

   // Grant selection: fixed index, or first valid channel after ptr (ptr itself last).
   always_comb begin
      grant_s       = '0;
      grant_valid_s = 1'b0;
      cand_s        = '0;
      if (mode_i) begin
         for (int k = 1; k <= N; k++) begin
            cand_s = {1'b0, ptr_q} + k[SW:0];
            if (cand_s >= N_C) begin
               cand_s = cand_s - N_C;
            end else begin
               cand_s = cand_s;
            end
            if (!grant_valid_s && in_valid_i[cand_s[SW-1:0]]) begin
               grant_valid_s = 1'b1;
               grant_s       = cand_s[SW-1:0];
            end else begin
               grant_valid_s = grant_valid_s;
            end
         end
      end else begin
         if (({1'b0, sel_i} < N_C) && in_valid_i[sel_i]) begin
            grant_valid_s = 1'b1;
            grant_s       = sel_i;
         end else begin
            grant_valid_s = 1'b0;
         end
      end
   end

   assign ld_ok_s = !out_valid_q || out_ready_i;
   assign hs_s    = grant_valid_s && ld_ok_s && rst_n;

   // One-hot accept towards the granted channel and its data selection.
   always_comb begin
      in_ready_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_s == i[SW-1:0]) begin
            in_ready_s[i] = hs_s;
            sel_data_s    = in_data_i[i*WIDTH +: WIDTH];
         end else begin
            in_ready_s[i] = 1'b0;
         end
      end
   end

   // Output register and pointer next-state; data/sel only change on a handshake.
   always_comb begin
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (hs_s) begin
         out_data_d  = sel_data_s;
         out_sel_d   = grant_s;
         out_valid_d = 1'b1;
         if (mode_i) begin
            ptr_d = grant_s;
         end else begin
            ptr_d = ptr_q;
         end
      end else if (ld_ok_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= PTR_RST;
      end else begin
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign in_ready_o  = in_ready_s;
   assign out_data_o  = out_data_q;
   assign out_sel_o   = out_sel_q;
   assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: a reference arbiter model pushes expected beats on
// input handshakes, and they are compared when the DUT presents them on its output.
module tb_rr_mux_arb;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [2:0]  sel;
   logic [31:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [3:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_sel;

   logic        mode6;
   logic [2:0]  sel6;
   logic [23:0] in_data6;
   logic [5:0]  in_valid6;
   logic [5:0]  in_ready6;
   logic [3:0]  out_data6;
   logic        out_valid6;
   logic        out_ready6;
   logic [2:0]  out_sel6;

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] sb_q[$];
   logic [2:0] ptr_m;
   logic [3:0] last_d_m;
   logic [2:0] last_s_m;

   rr_mux_arb #(.WIDTH(4), .N(8)) dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode), .sel_i(sel),
      .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_sel_o(out_sel)
   );

   rr_mux_arb #(.WIDTH(4), .N(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .mode_i(mode6), .sel_i(sel6),
      .in_data_i(in_data6), .in_valid_i(in_valid6), .in_ready_o(in_ready6),
      .out_data_o(out_data6), .out_valid_o(out_valid6), .out_ready_i(out_ready6),
      .out_sel_o(out_sel6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: check DUT against model at negedge, then advance the model.
   task automatic cyc();
      logic       gv;
      logic [2:0] g;
      logic [2:0] c;
      logic       ldok;
      logic [7:0] exp_ready;
      logic [6:0] beat;
      @(negedge clk);
      gv = 1'b0;
      g  = 3'd0;
      if (!mode) begin
         if (in_valid[sel]) begin
            gv = 1'b1;
            g  = sel;
         end
      end else begin
         for (int k = 1; k <= 8; k++) begin
            c = 3'((int'(ptr_m) + k) % 8);
            if (!gv && in_valid[c]) begin
               gv = 1'b1;
               g  = c;
            end
         end
      end
      ldok      = (sb_q.size() == 0) || out_ready;
      exp_ready = (gv && ldok) ? (8'h01 << g) : 8'h00;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check("out_data_hold", 32'(out_data), 32'(last_d_m));
      check("out_sel_hold", 32'(out_sel), 32'(last_s_m));
      if (out_valid && sb_q.size() != 0) begin
         beat = sb_q[0];
         check("beat_data", 32'(out_data), 32'(beat[3:0]));
         check("beat_sel", 32'(out_sel), 32'(beat[6:4]));
      end
      if (out_ready && sb_q.size() != 0) begin
         void'(sb_q.pop_front());
      end
      if (gv && ldok) begin
         beat = {g, in_data[g*4 +: 4]};
         sb_q.push_back(beat);
         last_d_m = beat[3:0];
         last_s_m = g;
         if (mode) ptr_m = g;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      sb_q.delete();
      ptr_m    = 3'd7;
      last_d_m = 4'h0;
      last_s_m = 3'd0;
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = 3'd0;
      in_data   = 32'h0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      mode6     = 1'b0;
      sel6      = 3'd0;
      in_data6  = 24'h0;
      in_valid6 = 6'h00;
      out_ready6 = 1'b1;
      model_reset();
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_sel", 32'(out_sel), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fixed select of channel 5.
      mode     = 1'b0;
      sel      = 3'd5;
      in_valid = 8'h20;
      in_data  = 32'h00A0_0000;
      cyc();
      in_valid = 8'h00;
      cyc();
      check("fixed_sel5", 32'(out_sel), 32'd5);
      cyc();

      // Full round robin after reset: 0..7,0.
      rst_n = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mode     = 1'b1;
      in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         in_data = $urandom;
         cyc();
      end

      // Two channels 0 and 7 alternate, pointer wraps.
      in_valid = 8'h81;
      for (int i = 0; i < 6; i++) begin
         in_data = $urandom;
         cyc();
      end

      // Stall for 3 cycles with everything valid, then resume without bubble.
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         cyc();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         cyc();
      end

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         mode      = 1'($urandom);
         sel       = 3'($urandom);
         in_valid  = 8'($urandom) & 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = $urandom;
         cyc();
      end

      // Asynchronous reset while a beat is held.
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      cyc();
      cyc();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_ready", 32'(in_ready), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 8'h08;
      in_data   = $urandom;
      cyc();
      in_valid = 8'h00;
      cyc();
      check("post_rst_sel3", 32'(out_sel), 32'd3);
      cyc();

      // N=6 instance: out-of-range select gives no grant.
      sel6      = 3'd3;
      in_valid6 = 6'h3F;
      in_data6  = 24'h00_5000;
      @(negedge clk);
      check("n6_ready_sel3", 32'(in_ready6), 32'h08);
      @(posedge clk);
      #1;
      sel6 = 3'd7;
      @(negedge clk);
      check("n6_valid", 32'(out_valid6), 32'd1);
      check("n6_data", 32'(out_data6), 32'h5);
      check("n6_sel", 32'(out_sel6), 32'd3);
      check("n6_ready_sel7", 32'(in_ready6), 32'h00);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("n6_drain", 32'(out_valid6), 32'd0);
      check("n6_ready_idle", 32'(in_ready6), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
